// File: rtl/sram_link_pkg.sv
`default_nettype none
// =============================================================================
// sram_link_pkg : link constants, state encoding and command byte layout shared
//                 by the SRAM command initiator and the SRAM controller.
// Revision      : 1.0
// =============================================================================
package sram_link_pkg;

   localparam int ADDR_W     = 5;
   localparam int READ_BIT   = 5;
   localparam int WORD_BYTES = 4;
   localparam int DATA_W     = 8 * WORD_BYTES;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } link_state_e;

   // Command byte: bits 7:6 reserved zero, READ_BIT set for reads, low bits address.
   function automatic logic [7:0] build_cmd(input logic we, input logic [ADDR_W-1:0] addr);
      logic [7:0] cmd;
      cmd                = '0;
      cmd[ADDR_W-1:0]    = addr;
      cmd[READ_BIT]      = ~we;
      return cmd;
   endfunction

   function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_link_timer.sv
`default_nettype none
// =============================================================================
// sram_link_timer : per-handshake wait counter; expired flags the last
//                   allowed cycle of a wait of TIMEOUT_CYCLES cycles.
// Revision        : 1.0
// =============================================================================
module sram_link_timer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   assign expired = run && (r_count == c_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (run && !expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_cmd_initiator.sv
`default_nettype none
// =============================================================================
// sram_cmd_initiator : turns word read/write requests into byte-serial command,
//                      write-data and read-response traffic on the SRAM link.
// Revision           : 1.0
// =============================================================================
module sram_cmd_initiator
   import sram_link_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              done,
   output logic              done_err,
   output logic [DATA_W-1:0] rdata,
   output logic [7:0]        cmd_data,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   input  logic [7:0]        rsp_data,
   input  logic              rsp_valid,
   output logic              rsp_ready,
   output logic              busy
);
   localparam logic [1:0] c_last_byte = 2'(WORD_BYTES - 1);

   link_state_e       r_state;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_byte_cnt;
   logic [DATA_W-9:0] r_rd_word;

   logic w_active;
   logic w_cmd_accept;
   logic w_rsp_accept;
   logic w_timeout;

   assign w_active     = (r_state == ST_CMD) || (r_state == ST_WDATA) || (r_state == ST_RDATA);
   assign w_cmd_accept = ((r_state == ST_CMD) || (r_state == ST_WDATA)) && cmd_valid && cmd_ready;
   assign w_rsp_accept = (r_state == ST_RDATA) && rsp_valid && rsp_ready;

   // Cleared outside the link states, so every state entry starts a fresh wait.
   sram_link_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!w_active || w_cmd_accept || w_rsp_accept),
      .run     (w_active),
      .expired (w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_data   <= '0;
         rsp_ready  <= 1'b0;
         done       <= 1'b0;
         done_err   <= 1'b0;
         rdata      <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_byte_cnt <= '0;
         r_rd_word  <= '0;
      end else begin
         done     <= 1'b0;
         done_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  r_we       <= req_we;
                  r_wdata    <= req_wdata;
                  cmd_data   <= build_cmd(req_we, req_addr);
                  cmd_valid  <= 1'b1;
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
                  r_byte_cnt <= '0;
                  r_state    <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (w_cmd_accept) begin
                  if (r_we) begin
                     cmd_data <= word_byte(r_wdata, 2'd0);
                     r_state  <= ST_WDATA;
                  end else begin
                     cmd_valid <= 1'b0;
                     rsp_ready <= 1'b1;
                     r_state   <= ST_RDATA;
                  end
               end else if (w_timeout) begin
                  cmd_valid <= 1'b0;
                  done      <= 1'b1;
                  done_err  <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_WDATA: begin
               if (w_cmd_accept) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == c_last_byte) begin
                     cmd_valid <= 1'b0;
                     done      <= 1'b1;
                     r_state   <= ST_DONE;
                  end else begin
                     cmd_data <= word_byte(r_wdata, r_byte_cnt + 2'd1);
                  end
               end else if (w_timeout) begin
                  cmd_valid <= 1'b0;
                  done      <= 1'b1;
                  done_err  <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_RDATA: begin
               if (w_rsp_accept) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  // Bytes shift in from the top so the first one ends up lowest.
                  if (r_byte_cnt == c_last_byte) begin
                     rdata     <= {rsp_data, r_rd_word};
                     rsp_ready <= 1'b0;
                     done      <= 1'b1;
                     r_state   <= ST_DONE;
                  end else begin
                     r_rd_word <= {rsp_data, r_rd_word[DATA_W-9:8]};
                  end
               end else if (w_timeout) begin
                  rsp_ready <= 1'b0;
                  done      <= 1'b1;
                  done_err  <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               req_ready  <= 1'b1;
               busy       <= 1'b0;
               r_byte_cnt <= '0;
               r_state    <= ST_IDLE;
            end
            default: begin
               req_ready  <= 1'b1;
               busy       <= 1'b0;
               cmd_valid  <= 1'b0;
               rsp_ready  <= 1'b0;
               r_byte_cnt <= '0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_cmd_initiator.sv
`default_nettype none
// =============================================================================
// tb_sram_cmd_initiator : bench acting as requester and SRAM controller, with a
//                         word-level model of the expected link traffic.
// Revision              : 1.0
// =============================================================================
module tb_sram_cmd_initiator;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        req_ready, done, done_err, busy;
   logic [31:0] rdata;
   logic [7:0]  cmd_data, rsp_data;
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;

   sram_cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .done_err(done_err), .rdata(rdata),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus plan
   int          cmd_stall[5];
   int          rsp_stall[4];
   logic [7:0]  rsp_bytes[4];
   bit          rsp_never;
   int          abort_at;
   bit          keep_valid;
   logic        nx_we;
   logic [4:0]  nx_addr;
   logic [31:0] nx_wdata;

   // observations
   logic [7:0]  obs_bytes[$];
   bit          got_cap, got_done;
   int          cap_cyc, done_cyc, unstable, busy_low, rr_high, n_rsp_acc, abort_done;
   logic        obs_err, obs_after_done, obs_cv_done, obs_rsp_done;
   logic        abort_cv, abort_rr, abort_busy;
   logic [31:0] obs_rdata;

   logic [31:0] rd_model;

   function automatic logic [43:0] pack_q(input logic [7:0] q[$]);
      logic [43:0] p;
      p = '0;
      p[43:40] = 4'(q.size());
      for (int i = 0; i < q.size() && i < 5; i++) p[8*i +: 8] = q[i];
      return p;
   endfunction

   // Expected link traffic for one request: command byte, then LSB-first data on writes.
   function automatic logic [43:0] exp_link(input logic we, input logic [4:0] addr, input logic [31:0] wd);
      logic [43:0] p;
      p = '0;
      p[43:40] = we ? 4'd5 : 4'd1;
      p[7:0]   = {2'b00, ~we, addr};
      if (we) for (int i = 0; i < 4; i++) p[8*(i+1) +: 8] = wd[8*i +: 8];
      return p;
   endfunction

   function automatic int exp_latency(input logic we);
      int l;
      l = 6 + cmd_stall[0];
      for (int i = 0; i < 4; i++) l += we ? cmd_stall[i+1] : rsp_stall[i];
      return l;
   endfunction

   task automatic clear_plan();
      for (int i = 0; i < 5; i++) cmd_stall[i] = 0;
      for (int i = 0; i < 4; i++) begin rsp_stall[i] = 0; rsp_bytes[i] = 8'($urandom); end
      rsp_never  = 0;
      abort_at   = -1;
      keep_valid = 0;
   endtask

   task automatic do_txn(input logic we, input logic [4:0] addr, input logic [31:0] wd);
      int n_cmd, n_rsp, cs, rs;
      bit stalled;
      logic [7:0] held;
      obs_bytes.delete();
      got_cap = 0; got_done = 0; unstable = 0; busy_low = 0; rr_high = 0;
      abort_done = 0; n_rsp_acc = 0; obs_err = 1'bx; obs_rdata = 'x; obs_after_done = 1'bx;
      req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      for (int g = 0; g < 50 && !got_cap; g++) begin
         @(negedge clk);
         if (req_ready) begin got_cap = 1; cap_cyc = cyc; end
      end
      if (!got_cap) begin req_valid = 1'b0; return; end
      @(posedge clk); #1;
      if (keep_valid) begin
         req_we = nx_we; req_addr = nx_addr; req_wdata = nx_wdata;
      end else begin
         req_valid = 1'b0; req_we = 1'($urandom); req_addr = 5'($urandom); req_wdata = $urandom;
      end
      n_cmd = 0; n_rsp = 0; cs = cmd_stall[0]; rs = rsp_stall[0]; stalled = 0; held = '0;
      for (int g = 0; g < 100 && !got_done; g++) begin
         cmd_ready = cmd_valid ? (cs == 0) : 1'($urandom);
         if (rsp_ready) begin
            rsp_valid = !rsp_never && rs == 0 && n_rsp < 4;
            rsp_data  = rsp_valid ? rsp_bytes[n_rsp] : 8'($urandom);
         end else begin
            rsp_valid = 1'($urandom); rsp_data = 8'($urandom);
         end
         @(negedge clk);
         if (abort_at >= 0 && n_cmd == abort_at && cmd_valid) begin
            rst_n = 1'b0; #1;
            abort_cv = cmd_valid; abort_rr = req_ready; abort_busy = busy;
            if (done) abort_done++;
            repeat (3) begin @(negedge clk); if (done) abort_done++; end
            rst_n = 1'b1;
            rd_model = '0;
            @(posedge clk); #1;
            return;
         end
         if (stalled && cmd_data !== held) unstable++;
         stalled = cmd_valid && !cmd_ready;
         held    = cmd_data;
         if (!busy) busy_low++;
         if (req_ready) rr_high++;
         if (cmd_valid && cmd_ready) begin
            obs_bytes.push_back(cmd_data);
            n_cmd++;
            cs = (n_cmd < 5) ? cmd_stall[n_cmd] : 0;
         end else if (cmd_valid && cs > 0) cs--;
         if (rsp_ready && rsp_valid) begin
            n_rsp++;
            rs = (n_rsp < 4) ? rsp_stall[n_rsp] : 0;
         end else if (rsp_ready && rs > 0) rs--;
         if (done) begin
            got_done = 1; done_cyc = cyc; obs_err = done_err; obs_rdata = rdata;
            obs_cv_done = cmd_valid; obs_rsp_done = rsp_ready;
         end
         @(posedge clk); #1;
      end
      n_rsp_acc = n_rsp;
      if (got_done) obs_after_done = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      cmd_ready = 0; rsp_valid = 0; rsp_data = 0;
      repeat (2) @(posedge clk); #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (cmd_data !== 8'h00) begin n_bad++; $display("FAIL rst_cmd_data: got %h want 00", cmd_data); end
      n_cmp++; if ({rsp_ready, done, done_err, busy} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {rsp_ready, done, done_err, busy}); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      rd_model = '0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_write_basic();
      clear_plan();
      do_txn(1'b1, 5'h03, 32'hDEADBEEF);
      n_cmp++; if (!got_cap || !got_done) begin n_bad++; $display("FAIL wr_complete: cap %0d done %0d want 1 1", got_cap, got_done); end
      n_cmp++; if (pack_q(obs_bytes) !== 44'h5_DE_AD_BE_EF_03) begin n_bad++; $display("FAIL wr_bytes: got %h want 5deadbeef03", pack_q(obs_bytes)); end
      n_cmp++; if (done_cyc - cap_cyc !== 6) begin n_bad++; $display("FAIL wr_latency: got %0d want 6", done_cyc - cap_cyc); end
      n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", obs_err); end
      n_cmp++; if (obs_after_done !== 1'b0) begin n_bad++; $display("FAIL wr_done_width: done after pulse %b want 0", obs_after_done); end
      n_cmp++; if (obs_rdata !== rd_model) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want %h", obs_rdata, rd_model); end
      n_cmp++; if (busy_low !== 0 || rr_high !== 0) begin n_bad++; $display("FAIL wr_busy: busy-low %0d ready-high %0d want 0 0", busy_low, rr_high); end
   endtask

   task automatic test_read_basic();
      clear_plan();
      rsp_bytes[0] = 8'h11; rsp_bytes[1] = 8'h22; rsp_bytes[2] = 8'h33; rsp_bytes[3] = 8'h44;
      do_txn(1'b0, 5'h1F, 32'h0);
      rd_model = 32'h44332211;
      n_cmp++; if (pack_q(obs_bytes) !== 44'h1_00_00_00_00_3F) begin n_bad++; $display("FAIL rd_cmd_byte: got %h want 10000000003f", pack_q(obs_bytes)); end
      n_cmp++; if (obs_rdata !== 32'h44332211) begin n_bad++; $display("FAIL rd_rdata: got %h want 44332211", obs_rdata); end
      n_cmp++; if (done_cyc - cap_cyc !== 6) begin n_bad++; $display("FAIL rd_latency: got %0d want 6", done_cyc - cap_cyc); end
      n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", obs_err); end
   endtask

   task automatic test_write_stall();
      clear_plan();
      cmd_stall[2] = 3;
      do_txn(1'b1, 5'h03, 32'hDEADBEEF);
      n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL stall_hold: cmd_data changed %0d times want 0", unstable); end
      n_cmp++; if (pack_q(obs_bytes) !== 44'h5_DE_AD_BE_EF_03) begin n_bad++; $display("FAIL stall_bytes: got %h want 5deadbeef03", pack_q(obs_bytes)); end
      n_cmp++; if (done_cyc - cap_cyc !== 9) begin n_bad++; $display("FAIL stall_latency: got %0d want 9", done_cyc - cap_cyc); end
      n_cmp++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL stall_err: got %b want 0", obs_err); end
   endtask

   task automatic test_read_timeout();
      clear_plan();
      rsp_never = 1;
      do_txn(1'b0, 5'h07, 32'h0);
      n_cmp++; if (!got_done || obs_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: done %0d err %b want 1 1", got_done, obs_err); end
      n_cmp++; if (done_cyc - cap_cyc !== 2 + TMO) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", done_cyc - cap_cyc, 2 + TMO); end
      n_cmp++; if (obs_rdata !== rd_model) begin n_bad++; $display("FAIL tmo_rdata_kept: got %h want %h", obs_rdata, rd_model); end
      n_cmp++; if ({obs_cv_done, obs_rsp_done} !== 2'b00) begin n_bad++; $display("FAIL tmo_drop: cmd_valid/rsp_ready %b want 00", {obs_cv_done, obs_rsp_done}); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] exp;
      clear_plan();
      abort_at = 3;
      do_txn(1'b1, 5'h12, 32'hA5C37E18);
      n_cmp++; if ({abort_cv, abort_rr, abort_busy} !== 3'b010) begin n_bad++; $display("FAIL abort_state: cv/rr/busy %b want 010", {abort_cv, abort_rr, abort_busy}); end
      n_cmp++; if (abort_done !== 0 || got_done) begin n_bad++; $display("FAIL abort_done: pulses %0d want 0", abort_done + int'(got_done)); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL abort_rdata: got %h want 0", rdata); end
      clear_plan();
      exp = {rsp_bytes[3], rsp_bytes[2], rsp_bytes[1], rsp_bytes[0]};
      do_txn(1'b0, 5'h09, 32'h0);
      rd_model = exp;
      n_cmp++; if (obs_rdata !== exp || obs_err !== 1'b0) begin n_bad++; $display("FAIL post_abort_read: rdata %h err %b want %h 0", obs_rdata, obs_err, exp); end
      n_cmp++; if (pack_q(obs_bytes) !== exp_link(1'b0, 5'h09, 32'h0)) begin n_bad++; $display("FAIL post_abort_bytes: got %h want %h", pack_q(obs_bytes), exp_link(1'b0, 5'h09, 32'h0)); end
   endtask

   task automatic test_back_to_back();
      int done1, rr1;
      logic [43:0] b1;
      logic [31:0] exp;
      clear_plan();
      keep_valid = 1; nx_we = 1'b0; nx_addr = 5'h0A; nx_wdata = 32'h0;
      exp = {rsp_bytes[3], rsp_bytes[2], rsp_bytes[1], rsp_bytes[0]};
      do_txn(1'b1, 5'h15, 32'h01234567);
      done1 = done_cyc; rr1 = rr_high; b1 = pack_q(obs_bytes);
      keep_valid = 0;
      do_txn(1'b0, 5'h0A, 32'h0);
      rd_model = exp;
      n_cmp++; if (rr1 !== 0) begin n_bad++; $display("FAIL b2b_stall: req_ready high %0d cycles while busy want 0", rr1); end
      n_cmp++; if (b1 !== exp_link(1'b1, 5'h15, 32'h01234567)) begin n_bad++; $display("FAIL b2b_first_bytes: got %h want %h", b1, exp_link(1'b1, 5'h15, 32'h01234567)); end
      n_cmp++; if (cap_cyc !== done1 + 1) begin n_bad++; $display("FAIL b2b_accept: second capture at %0d want %0d", cap_cyc, done1 + 1); end
      n_cmp++; if (pack_q(obs_bytes) !== exp_link(1'b0, 5'h0A, 32'h0) || obs_rdata !== exp) begin n_bad++; $display("FAIL b2b_second: bytes %h rdata %h want %h %h", pack_q(obs_bytes), obs_rdata, exp_link(1'b0, 5'h0A, 32'h0), exp); end
   endtask

   task automatic test_random();
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wd, exp;
      for (int t = 0; t < 24; t++) begin
         clear_plan();
         we = 1'($urandom); addr = 5'($urandom); wd = $urandom;
         for (int i = 0; i < 5; i++) cmd_stall[i] = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) rsp_stall[i] = $urandom_range(0, 3);
         exp = we ? rd_model : {rsp_bytes[3], rsp_bytes[2], rsp_bytes[1], rsp_bytes[0]};
         do_txn(we, addr, wd);
         rd_model = exp;
         n_cmp++; if (pack_q(obs_bytes) !== exp_link(we, addr, wd)) begin n_bad++; $display("FAIL rnd%0d_bytes: got %h want %h", t, pack_q(obs_bytes), exp_link(we, addr, wd)); end
         n_cmp++; if (!got_done || done_cyc - cap_cyc !== exp_latency(we)) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, got_done ? done_cyc - cap_cyc : -1, exp_latency(we)); end
         n_cmp++; if (obs_rdata !== exp || obs_err !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_result: rdata %h err %b want %h 0", t, obs_rdata, obs_err, exp); end
         n_cmp++; if (unstable !== 0 || obs_after_done !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_link: unstable %0d done-after %b want 0 0", t, unstable, obs_after_done); end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_write_stall();
      test_read_timeout();
      test_reset_midflight();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_cmd_initiator.md
SRAM_CMD_INITIATOR -- requirements
Module: sram_cmd_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles the block waits for any single link handshake before abort.
REQ-002 SHALL have ports clk (input, 1, single clock) and rst_n (input, 1, reset): one clock, asynchronous active-low reset.
REQ-003 SHALL have ports req_valid (input, 1, request offered) and req_ready (output, 1, request accepted).
REQ-004 SHALL have ports req_we (input, 1, 1=write 0=read), req_addr (input, 5, word address) and req_wdata (input, 32, write data).
REQ-005 SHALL have ports done (output, 1, one-cycle completion pulse), done_err (output, 1, timeout flag valid with done) and rdata (output, 32, read result valid with done).
REQ-006 SHALL have ports cmd_data (output, 8, byte to controller), cmd_valid (output, 1) and cmd_ready (input, 1, controller accepts byte).
REQ-007 SHALL have ports rsp_data (input, 8, byte from controller), rsp_valid (input, 1) and rsp_ready (output, 1, initiator can take byte).
REQ-008 SHALL have port busy (output, 1, high in any state other than IDLE).

Function
REQ-009 SHALL transfer a link byte only in a cycle where valid and ready are both high; cmd_data SHALL stay stable while cmd_valid is high and not accepted.
REQ-010 SHALL build the command byte as {2'b00, ~req_we, req_addr}: bit5=1 read, bit5=0 write, bits4:0 address.
REQ-011 SHALL drive req_ready high only in IDLE; a request SHALL be captured (we, addr, wdata) on req_valid && req_ready.
REQ-012 SHALL use states IDLE, CMD, WDATA, RDATA, DONE.
REQ-013 Transitions: IDLE->CMD on request capture; CMD->WDATA (write) or CMD->RDATA (read) on command byte accept; WDATA->DONE after the 4th data byte is accepted; RDATA->DONE after the 4th response byte is accepted; DONE->IDLE unconditionally.
REQ-014 In WDATA SHALL send wdata bytes LSB first: [7:0], [15:8], [23:16], [31:24], tracked by a 2-bit byte counter that increments on each accept.
REQ-015 In RDATA SHALL hold rsp_ready high and assemble response bytes LSB first: 1st byte -> rdata[7:0], 4th byte -> rdata[31:24].
REQ-016 rsp_ready SHALL be low in all states except RDATA; rsp_valid outside RDATA SHALL be ignored.
REQ-017 In DONE SHALL pulse done for exactly one cycle; rdata SHALL hold the last assembled word until the next read completes; on writes rdata SHALL be unchanged.
REQ-018 Minimum write latency, capture to done: 6 cycles (1 CMD + 4 WDATA with cmd_ready tied high, + DONE).
REQ-019 Minimum read latency, capture to done: 6 cycles (1 CMD + 4 RDATA with rsp_valid high every cycle, + DONE).
REQ-020 A wait counter SHALL reset on every accepted byte and on state entry; if it reaches TIMEOUT_CYCLES in CMD, WDATA or RDATA, the block SHALL go to DONE with done_err=1, drop cmd_valid and drop rsp_ready.
REQ-021 done_err SHALL be 0 on any completion without timeout; rdata SHALL be unchanged on a timed-out read.
REQ-022 A req_valid arriving while busy SHALL be stalled (req_ready=0) and never dropped or merged.

Reset
REQ-023 On rst_n low SHALL asynchronously enter IDLE; an in-flight transaction SHALL be abandoned without a done pulse.
REQ-024 Reset values SHALL be: req_ready=1 (IDLE), cmd_valid=0, cmd_data=0, rsp_ready=0, done=0, done_err=0, rdata=0, busy=0, byte counter=0, wait counter=0.

Structure
REQ-025 Package sram_link_pkg SHALL hold: READ_BIT=5, ADDR_W=5, WORD_BYTES=4, the state encoding and the command-byte bit layout, shared with the SRAM controller.
REQ-026 The wait counter SHALL be a sub-module sram_link_timer (inputs clear and run, output expired); everything else SHALL stay in one module.

Verification
REQ-027 Write addr=5'h03, wdata=32'hDEADBEEF, cmd_ready=1 -> bytes 8'h03, EF, BE, AD, DE on consecutive cycles; done 6 cycles after capture; done_err=0.
REQ-028 Read addr=5'h1F; controller returns 8'h11, 22, 33, 44 -> command byte 8'h3F; rdata=32'h44332211 with done; done_err=0.
REQ-029 Write with cmd_ready low for 3 cycles on the 2nd data byte -> cmd_data holds 8'hBE for the stall; byte order unchanged; completes normally.
REQ-030 Read with rsp_valid never asserted, TIMEOUT_CYCLES=8 -> done with done_err=1 after 8 RDATA cycles; rdata keeps its previous value.
REQ-031 rst_n low during the 3rd write data byte -> next cycle IDLE, cmd_valid=0, no done pulse; a following read completes correctly.
REQ-032 req_valid held high across two back-to-back requests -> second is accepted only after DONE returns to IDLE; both produce correct link traffic.
